// File: rtl/dror_sweep_scheduler.sv
// ============================================================================
// Module   : dror_sweep_scheduler
// Summary  : Sequences one DROR filtering pass: per query point, streams every
//            other stored point in DISTANCE_MODULES-wide batches to the
//            validator core and returns one inlier/outlier verdict per point.
//            Optional macro DROR_SWEEP_PERF_EN adds the o_perf_batches counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dror_sweep_scheduler #(
    parameter int N                 = 16,
    parameter int DISTANCE_MODULES  = 8,
    parameter int VERDICT_LATENCY   = 4,
    parameter int NEIGHBOR_TRESHOLD = 5
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic [2*N-1:0]                i_cloud_size,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_rd_en,
    output logic [2*N-1:0]                o_rd_addr,
    input  logic                          i_rd_valid,
    input  logic [N-1:0]                  i_rd_x,
    input  logic [N-1:0]                  i_rd_y,
    input  logic [N-1:0]                  i_rd_z,
    output logic                          o_core_rst,
    output logic                          o_core_valid,
    output logic [N-1:0]                  o_point_x,
    output logic [N-1:0]                  o_point_y,
    output logic [N-1:0]                  o_point_z,
    output logic [N*DISTANCE_MODULES-1:0] o_cp_x,
    output logic [N*DISTANCE_MODULES-1:0] o_cp_y,
    output logic [N*DISTANCE_MODULES-1:0] o_cp_z,
    output logic [DISTANCE_MODULES-1:0]   o_cp_mask,
    input  logic                          i_inlier,
    input  logic                          i_outlier,
    output logic                          o_res_valid,
    input  logic                          i_res_ready,
    output logic [2*N-1:0]                o_res_index,
    output logic                          o_res_inlier
`ifdef DROR_SWEEP_PERF_EN
    ,
    output logic [2*N-1:0]                o_perf_batches
`endif
);

    localparam int c_SW = $clog2(DISTANCE_MODULES + 1);
    localparam int c_LW = $clog2(VERDICT_LATENCY + 1);
    localparam logic [2*N-1:0] c_ONE = 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_Q = 3'd1;
    localparam logic [2:0] S_FILL   = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_REPORT = 3'd5;

    logic [2:0]                    r_state;
    logic [2*N-1:0]                r_size, r_q, r_p, r_rd_addr;
    logic [c_SW-1:0]               r_slot;
    logic [c_LW-1:0]               r_lat;
    logic [DISTANCE_MODULES-1:0]   r_mask;
    logic [N*DISTANCE_MODULES-1:0] r_cp_x, r_cp_y, r_cp_z;
    logic [N-1:0]                  r_pt_x, r_pt_y, r_pt_z;
    logic                          r_rd_en, r_rd_pend, r_rd_req, r_inl, r_done;

    logic                          w_fill_full, w_p_end;
    logic [2*N-1:0]                w_q_next;
    logic                          w_unused_ok;

    assign w_fill_full = (r_slot == c_SW'(DISTANCE_MODULES));
    assign w_p_end     = (r_p == r_size);
    assign w_q_next    = r_q + c_ONE;
    // The verdict is "inlier seen or not"; i_outlier and the threshold are informative only.
    assign w_unused_ok = i_outlier ^ (NEIGHBOR_TRESHOLD > 0);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_size    <= '0;
            r_q       <= '0;
            r_p       <= '0;
            r_rd_addr <= '0;
            r_slot    <= '0;
            r_lat     <= '0;
            r_mask    <= '0;
            r_cp_x    <= '0;
            r_cp_y    <= '0;
            r_cp_z    <= '0;
            r_pt_x    <= '0;
            r_pt_y    <= '0;
            r_pt_z    <= '0;
            r_rd_en   <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rd_req  <= 1'b0;
            r_inl     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            // r_rd_pend tracks any read in flight, including one abandoned by an early exit.
            if (i_rd_valid) begin
                r_rd_pend <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_size <= i_cloud_size;
                        r_q    <= '0;
                        if (i_cloud_size == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_LOAD_Q;
                        end
                    end
                end
                S_LOAD_Q: begin
                    if (!r_rd_req) begin
                        if (!r_rd_pend) begin
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= r_q;
                            r_rd_pend <= 1'b1;
                            r_rd_req  <= 1'b1;
                        end
                    end else if (i_rd_valid) begin
                        r_rd_req <= 1'b0;
                        r_pt_x   <= i_rd_x;
                        r_pt_y   <= i_rd_y;
                        r_pt_z   <= i_rd_z;
                        r_p      <= '0;
                        r_slot   <= '0;
                        r_mask   <= '0;
                        r_cp_x   <= '0;
                        r_cp_y   <= '0;
                        r_cp_z   <= '0;
                        r_inl    <= 1'b0;
                        r_state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (i_inlier) begin
                        r_inl    <= 1'b1;
                        r_rd_req <= 1'b0;
                        r_state  <= S_REPORT;
                    end else if (w_fill_full || w_p_end) begin
                        // An empty batch is never issued; straight to the verdict wait.
                        if (r_slot != '0) begin
                            r_state <= S_ISSUE;
                        end else begin
                            r_lat   <= '0;
                            r_state <= S_DRAIN;
                        end
                    end else if (r_p == r_q) begin
                        r_p <= r_p + c_ONE;
                    end else if (!r_rd_req) begin
                        if (!r_rd_pend) begin
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= r_p;
                            r_rd_pend <= 1'b1;
                            r_rd_req  <= 1'b1;
                        end
                    end else if (i_rd_valid) begin
                        r_rd_req <= 1'b0;
                        for (int k = 0; k < DISTANCE_MODULES; k++) begin
                            if (r_slot == c_SW'(k)) begin
                                r_mask[k]         <= 1'b1;
                                r_cp_x[k*N +: N]  <= i_rd_x;
                                r_cp_y[k*N +: N]  <= i_rd_y;
                                r_cp_z[k*N +: N]  <= i_rd_z;
                            end
                        end
                        r_slot <= r_slot + c_SW'(1);
                        r_p    <= r_p + c_ONE;
                    end
                end
                S_ISSUE: begin
                    if (i_inlier) begin
                        r_inl   <= 1'b1;
                        r_state <= S_REPORT;
                    end else begin
                        r_slot <= '0;
                        r_mask <= '0;
                        r_cp_x <= '0;
                        r_cp_y <= '0;
                        r_cp_z <= '0;
                        if (r_p < r_size) begin
                            r_state <= S_FILL;
                        end else begin
                            r_lat   <= '0;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_inlier) begin
                        r_inl <= 1'b1;
                    end
                    if (r_lat == c_LW'(VERDICT_LATENCY - 1)) begin
                        r_state <= S_REPORT;
                    end else begin
                        r_lat <= r_lat + c_LW'(1);
                    end
                end
                S_REPORT: begin
                    if (i_res_ready) begin
                        r_q <= w_q_next;
                        if (w_q_next < r_size) begin
                            r_state <= S_LOAD_Q;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DROR_SWEEP_PERF_EN
    logic [2*N-1:0] r_perf;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_perf <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_perf <= '0;
        end else if (r_state == S_ISSUE && r_perf != '1) begin
            r_perf <= r_perf + c_ONE;
        end
    end

    assign o_perf_batches = r_perf;
`endif

    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_rd_en      = r_rd_en;
    assign o_rd_addr    = r_rd_addr;
    assign o_core_rst   = (r_state == S_IDLE) || (r_state == S_LOAD_Q);
    assign o_core_valid = (r_state == S_ISSUE);
    assign o_point_x    = r_pt_x;
    assign o_point_y    = r_pt_y;
    assign o_point_z    = r_pt_z;
    assign o_cp_x       = r_cp_x;
    assign o_cp_y       = r_cp_y;
    assign o_cp_z       = r_cp_z;
    assign o_cp_mask    = r_mask;
    assign o_res_valid  = (r_state == S_REPORT);
    assign o_res_index  = (r_state == S_REPORT) ? r_q : '0;
    assign o_res_inlier = (r_state == S_REPORT) && r_inl;

endmodule

`default_nettype wire

// File: tb/tb_dror_sweep_scheduler.sv
// ============================================================================
// Module   : tb_dror_sweep_scheduler
// Summary  : Directed self-checking bench for dror_sweep_scheduler with a
//            single-outstanding memory model and result/batch logging.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dror_sweep_scheduler;

    localparam int N  = 16;
    localparam int DM = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_start = 1'b0;
    logic [2*N-1:0]    i_cloud_size = '0;
    logic              o_busy, o_done, o_rd_en;
    logic [2*N-1:0]    o_rd_addr;
    logic              i_rd_valid = 1'b0;
    logic [N-1:0]      i_rd_x = '0, i_rd_y = '0, i_rd_z = '0;
    logic              o_core_rst, o_core_valid;
    logic [N-1:0]      o_point_x, o_point_y, o_point_z;
    logic [N*DM-1:0]   o_cp_x, o_cp_y, o_cp_z;
    logic [DM-1:0]     o_cp_mask;
    logic              i_inlier = 1'b0;
    logic              i_outlier = 1'b0;
    logic              o_res_valid;
    logic              i_res_ready = 1'b1;
    logic [2*N-1:0]    o_res_index;
    logic              o_res_inlier;
`ifdef DROR_SWEEP_PERF_EN
    logic [2*N-1:0]    o_perf_batches;
`endif

    dror_sweep_scheduler #(.N(N), .DISTANCE_MODULES(DM), .VERDICT_LATENCY(4), .NEIGHBOR_TRESHOLD(5)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(i_start), .i_cloud_size(i_cloud_size),
        .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
        .i_rd_valid(i_rd_valid), .i_rd_x(i_rd_x), .i_rd_y(i_rd_y), .i_rd_z(i_rd_z),
        .o_core_rst(o_core_rst), .o_core_valid(o_core_valid),
        .o_point_x(o_point_x), .o_point_y(o_point_y), .o_point_z(o_point_z),
        .o_cp_x(o_cp_x), .o_cp_y(o_cp_y), .o_cp_z(o_cp_z), .o_cp_mask(o_cp_mask),
        .i_inlier(i_inlier), .i_outlier(i_outlier), .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready), .o_res_index(o_res_index), .o_res_inlier(o_res_inlier)
`ifdef DROR_SWEEP_PERF_EN
        , .o_perf_batches(o_perf_batches)
`endif
    );

    always #5 clk = ~clk;

    logic [N-1:0]    mem_x [64];
    logic [N-1:0]    mem_y [64];
    logic [N-1:0]    mem_z [64];
    int              m_lat = 1;
    int              m_cnt = 0;
    logic            m_out = 1'b0;
    logic [5:0]      m_addr = '0;
    int              rd_viol = 0;
    int              done_cnt = 0;
    int              busy_cnt = 0;
    logic            xfer_d = 1'b0;
    logic            early_arm = 1'b0;
    logic            early_hold = 1'b0;
    logic            early_req = 1'b0;

    logic [2*N-1:0]  rd_log [$];
    logic [DM-1:0]   bmask [$];
    logic [N*DM-1:0] bx [$];
    logic [2*N-1:0]  ridx [$];
    logic            rinl [$];
    int              rbc [$];
    logic            rst_after [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitors plus a single-outstanding memory responder, all on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            m_cnt = 0;
            m_out = 1'b0;
            i_rd_valid = 1'b0;
            xfer_d = 1'b0;
            early_arm = 1'b0;
            early_hold = 1'b0;
            i_inlier = 1'b0;
        end else begin
            if (o_busy) busy_cnt++;
            if (o_done) done_cnt++;
            if (o_core_valid) begin
                bmask.push_back(o_cp_mask);
                bx.push_back(o_cp_x);
            end
            if (xfer_d) rst_after.push_back(o_core_rst);
            xfer_d = o_res_valid && i_res_ready;
            if (xfer_d) begin
                ridx.push_back(o_res_index);
                rinl.push_back(o_res_inlier);
                rbc.push_back(bmask.size());
            end
            if (early_req && !early_arm && !early_hold && o_core_rst) early_arm = 1'b1;
            if (early_arm && o_core_valid) begin
                i_inlier = 1'b1;
                early_arm = 1'b0;
                early_hold = 1'b1;
            end else if (early_hold && o_core_rst) begin
                i_inlier = 1'b0;
            end
            i_rd_valid = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    i_rd_valid = 1'b1;
                    i_rd_x = mem_x[m_addr];
                    i_rd_y = mem_y[m_addr];
                    i_rd_z = mem_z[m_addr];
                    m_out = 1'b0;
                end
            end
            if (o_rd_en) begin
                if (m_out) rd_viol++;
                m_out = 1'b1;
                m_addr = o_rd_addr[5:0];
                m_cnt = m_lat;
                rd_log.push_back(o_rd_addr);
            end
        end
    end

    task automatic start_pass(input logic [2*N-1:0] s);
        @(negedge clk);
        i_cloud_size = s;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int maxc);
        int c = 0;
        while (done_cnt == base && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (done_cnt == base) chk("timeout_done", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int db, rb, bb, lb, vb, c;
        for (int a = 0; a < 64; a++) begin
            mem_x[a] = N'(a + 100);
            mem_y[a] = N'(a + 200);
            mem_z[a] = N'(a + 300);
        end
        repeat (3) @(negedge clk);
        chk("reset_outs", {58'd0, o_busy, o_done, o_rd_en, o_core_valid, o_res_valid, o_core_rst}, 64'd1);
        chk("reset_mask", {56'd0, o_cp_mask}, 64'd0);
        rst = 1'b0;

        // Empty cloud: done pulse only.
        vb = busy_cnt; lb = rd_log.size();
        start_pass(0);
        chk("s0_done_pulse", {63'd0, o_done}, 64'd1);
        @(negedge clk);
        chk("s0_done_low", {63'd0, o_done}, 64'd0);
        chk("s0_busy_never", 64'(busy_cnt - vb), 64'd0);
        chk("s0_no_reads", 64'(rd_log.size() - lb), 64'd0);

        // Single point: one read, no batch, outlier.
        mem_x[0] = 16'd3; mem_y[0] = 16'd4; mem_z[0] = 16'd0;
        db = done_cnt; rb = ridx.size(); bb = bmask.size(); lb = rd_log.size();
        start_pass(1);
        wait_done(db, 200);
        chk("s1_reads", 64'(rd_log.size() - lb), 64'd1);
        chk("s1_rd_addr", 64'(rd_log[lb]), 64'd0);
        chk("s1_batches", 64'(bmask.size() - bb), 64'd0);
        chk("s1_results", 64'(ridx.size() - rb), 64'd1);
        chk("s1_idx", 64'(ridx[rb]), 64'd0);
        chk("s1_inlier", {63'd0, rinl[rb]}, 64'd0);
        chk("s1_point", {16'd0, o_point_x, o_point_y, o_point_z}, {16'd0, 16'd3, 16'd4, 16'd0});
        mem_x[0] = 16'd100; mem_y[0] = 16'd200; mem_z[0] = 16'd300;

        // Ten points, all outliers: two batches per query.
        m_lat = 3;
        db = done_cnt; rb = ridx.size(); bb = bmask.size(); lb = rd_log.size();
        start_pass(10);
        wait_done(db, 5000);
        for (int i = 0; i < 10; i++) chk("s10_rd_order", 64'(rd_log[lb + i]), 64'(i));
        chk("s10_b1_mask", {56'd0, bmask[bb]}, 64'hFF);
        chk("s10_b1_lo", bx[bb][63:0], 64'h0068_0067_0066_0065);
        chk("s10_b1_hi", bx[bb][127:64], 64'h006C_006B_006A_0069);
        chk("s10_b2_mask", {56'd0, bmask[bb + 1]}, 64'h01);
        chk("s10_b2_data", bx[bb + 1][63:0], 64'h0000_0000_0000_006D);
        chk("s10_last_mask", {56'd0, bmask[bb + 19]}, 64'h01);
        chk("s10_last_slot0", 64'(bx[bb + 19][15:0]), 64'd108);
        chk("s10_batches", 64'(bmask.size() - bb), 64'd20);
        chk("s10_reads", 64'(rd_log.size() - lb), 64'd100);
        chk("s10_results", 64'(ridx.size() - rb), 64'd10);
        for (int i = 0; i < 10; i++) begin
            chk("s10_idx", 64'(ridx[rb + i]), 64'(i));
            chk("s10_inl", {63'd0, rinl[rb + i]}, 64'd0);
        end
`ifdef DROR_SWEEP_PERF_EN
        chk("s10_perf", 64'(o_perf_batches), 64'd20);
`endif

        // Early exit on query 0 after its first batch.
        m_lat = 1;
        db = done_cnt; rb = ridx.size(); bb = bmask.size();
        early_req = 1'b1;
        start_pass(40);
        wait_done(db, 30000);
        early_req = 1'b0;
        chk("ee_results", 64'(ridx.size() - rb), 64'd40);
        chk("ee_q0_inlier", {63'd0, rinl[rb]}, 64'd1);
        chk("ee_q0_batches", 64'(rbc[rb] - bb), 64'd1);
        chk("ee_q1_core_rst", {63'd0, rst_after[rb]}, 64'd1);
        chk("ee_q1_inlier", {63'd0, rinl[rb + 1]}, 64'd0);
        chk("ee_batches", 64'(bmask.size() - bb), 64'd196);

        // Back-pressure on the result port.
        i_res_ready = 1'b0;
        db = done_cnt; rb = ridx.size();
        start_pass(2);
        c = 0;
        while (!o_res_valid && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("bp_valid_seen", {63'd0, o_res_valid}, 64'd1);
        lb = rd_log.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {30'd0, o_res_valid, o_res_index, o_res_inlier}, {30'd0, 1'b1, 32'd0, 1'b0});
        end
        chk("bp_no_reads", 64'(rd_log.size() - lb), 64'd0);
        i_res_ready = 1'b1;
        wait_done(db, 500);
        chk("bp_results", 64'(ridx.size() - rb), 64'd2);

        // Reset mid-FILL abandons the pass.
        db = done_cnt; lb = rd_log.size();
        start_pass(20);
        c = 0;
        while (rd_log.size() < lb + 3 && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("rst_reached_fill", 64'(rd_log.size() >= lb + 3), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outs", {58'd0, o_busy, o_done, o_rd_en, o_core_valid, o_res_valid, o_core_rst}, 64'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt - db), 64'd0);
        db = done_cnt; rb = ridx.size();
        start_pass(2);
        wait_done(db, 500);
        chk("rst_s2_results", 64'(ridx.size() - rb), 64'd2);
        chk("rst_s2_idx1", 64'(ridx[rb + 1]), 64'd1);
        chk("rst_s2_done", 64'(done_cnt - db), 64'd1);
        chk("rd_outstanding", 64'(rd_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dror_sweep_scheduler.md
Name: dror_sweep_scheduler

Overview:
- Sequences one full DROR filtering pass over a stored point cloud.
- For each query point q: fetches q, then streams every other point in batches of DISTANCE_MODULES into the validator datapath.
- Collects the inlier/outlier verdict for q and returns one result per point over a ready/valid port.
- Sits between the point-cloud memory and the validator core; it is the only master of both.

Parameters:
- N, 16, coordinate width in bits.
- DISTANCE_MODULES, 8, comparison slots per batch.
- VERDICT_LATENCY, 4, cycles from the last batch issued until the datapath verdict is final.
- NEIGHBOR_TRESHOLD, 5, neighbour count the datapath must reach for an inlier; early-exit reference only.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_start  in  1  start pass; sampled in IDLE only
- i_cloud_size  in  2N  number of points; 0 and 1 are legal
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  one-cycle pulse at end of pass
- o_rd_en  out  1  one-cycle memory read request
- o_rd_addr  out  2N  read index
- i_rd_valid  in  1  read data valid; arbitrary latency, at most one read outstanding
- i_rd_x, i_rd_y, i_rd_z  in  N each  read data
- o_core_rst  out  1  clears datapath counters before each query
- o_core_valid  out  1  batch present on the cp buses this cycle
- o_point_x, o_point_y, o_point_z  out  N each  query point, held stable for the whole query
- o_cp_x, o_cp_y, o_cp_z  out  N*DISTANCE_MODULES each  packed batch; slot k occupies bits [(k+1)N-1:kN]
- o_cp_mask  out  DISTANCE_MODULES  per-slot valid bit
- i_inlier, i_outlier  in  1 each  datapath verdict
- o_res_valid  out  1  result available
- i_res_ready  in  1  result accepted
- o_res_index  out  2N  query index of the result
- o_res_inlier  out  1  1 = inlier, 0 = outlier

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, except o_core_rst = 1 while in IDLE.
  - Reset mid-pass abandons the pass; no o_done, and any pending result is dropped.
- FSM states: IDLE, LOAD_Q, FILL, ISSUE, DRAIN, REPORT.
- IDLE:
  - On i_start=1, latch size S, set q=0 and go to LOAD_Q.
  - If S==0, pulse o_done the next cycle and stay IDLE; o_busy is never asserted.
- LOAD_Q:
  - Issue read addr q and wait for i_rd_valid.
  - Latch the query point into o_point_*.
  - Assert o_core_rst for exactly this state.
  - Set p=0, slot=0, clear mask, go to FILL.
- FILL:
  - Skip p==q without a read (a point is never its own neighbour).
  - Otherwise read addr p; on i_rd_valid write slot, set mask[slot], slot++, p++.
  - Go to ISSUE when slot==DISTANCE_MODULES or p==S.
- ISSUE:
  - Assert o_core_valid for exactly 1 cycle.
  - A partial last batch keeps its unused slots with mask=0 and zeroed coordinates.
  - Then clear slot and mask.
  - If p<S, go to FILL; else go to DRAIN.
- Early exit: i_inlier=1 seen in FILL or ISSUE goes straight to REPORT with inlier=1. Remaining batches are not issued; an outstanding read completes and is discarded.
- DRAIN:
  - Wait VERDICT_LATENCY cycles.
  - Verdict is inlier if i_inlier was seen at any point; otherwise outlier, even if i_outlier never rose.
  - S==1 issues no batch and reports outlier.
- REPORT:
  - o_res_valid is held with stable index and inlier until i_res_ready; transfer happens when both are high.
  - Then q++: if q<S go to LOAD_Q; else pulse o_done and go to IDLE.
- o_rd_en is never asserted while a read is outstanding.
- i_start is ignored while busy.
- Throughput: one batch per DISTANCE_MODULES+1 read-latency-bound cycles minimum.

Optional Feature:
- Macro DROR_SWEEP_PERF_EN.
- Defined: adds output o_perf_batches (2N bits), the batches issued in the current pass. It clears on accepted start, saturates at all-ones, and holds after o_done until the next start.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- S=0, start -> o_done pulse 1 cycle later, o_busy never high, no reads.
- S=1, point (3,4,0) -> one LOAD_Q read, zero batches, one result idx0 inlier=0, then o_done.
- DISTANCE_MODULES=8, S=10, query q=0 -> batch1 mask 0xFF holding addrs 1-8, batch2 mask 0x01 holding addr 9; addr 0 is never read in FILL.
- i_inlier forced high after first batch, S=40 -> REPORT inlier=1, only 1 batch issued for that query, next query starts with o_core_rst high.
- i_res_ready held low 5 cycles -> o_res_valid, o_res_index and o_res_inlier stable for all 5; no new reads issued.
- Assert i_reset during FILL at S=20 -> next cycle outputs 0 and IDLE; a following start with S=2 produces exactly 2 results and o_done.
